ft232h_fifo_responder: RTL and testbench

Synthesizable device-side model of the FT232H synchronous 245-FIFO interface. It plays the chip's role against the FPGA-side USB bridge and is used both for hardware-in-loop loopback builds and as the bench partner of the bridge. Host-to-FPGA bytes enter on a valid/ready stream and are presented on the FT bus via RXF#. FPGA-to-host bytes are accepted on WR# under TXE# pacing and leave on a second valid/ready stream.

---
 rtl/ft232h_pkg.sv | 14 +
 rtl/ft232h_fifo_responder_sync_fifo_sa.sv | 50 +++++
 rtl/ft232h_fifo_responder.sv | 143 ++++++++++++++
 tb/tb_ft232h_fifo_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ft232h_pkg.sv
// Shared definitions for the FT232H synchronous 245-FIFO responder.
package ft232h_pkg;

  localparam int ERR_TXE_WR   = 0;
  localparam int ERR_RXF_RD   = 1;
  localparam int ERR_RD_NO_OE = 2;
  localparam int ERR_OE_WR    = 3;

  typedef enum logic {
    OPEN = 1'b0,
    GAP  = 1'b1
  } txe_state_t;

endpackage

// File: rtl/ft232h_fifo_responder_sync_fifo_sa.sv
// Single-clock show-ahead FIFO; a pop frees the slot for a same-cycle push when full.
module sync_fifo_sa #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LW-1:0]    level_o,
  output logic [LW-1:0]    level_next_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty_o      = (level_q == LW'(0));
  assign full_o       = (level_q == LW'(DEPTH));
  assign do_pop       = pop_i && !empty_o;
  assign do_push      = push_i && (!full_o || do_pop);
  assign level_next_o = level_q + LW'(do_push) - LW'(do_pop);
  assign level_o      = level_q;
  assign data_o       = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_next_o;
    end
  end

  // Storage needs no reset: the level masks stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ft232h_fifo_responder.sv
// Device-side model of the FT232H sync 245-FIFO: RX/TX buffers, RXF#/TXE# pacing, error flags.
module ft232h_fifo_responder
  import ft232h_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int TX_BURST = 512,
  parameter int TX_GAP   = 8,
  localparam int RLW = $clog2(RX_DEPTH) + 1,
  localparam int TLW = $clog2(TX_DEPTH) + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [7:0]     ft_data_i,
  output logic [7:0]     ft_data_o,
  output logic           ft_data_oe_o,
  output logic           ft_rxf_n_o,
  output logic           ft_txe_n_o,
  input  logic           ft_rd_n_i,
  input  logic           ft_wr_n_i,
  input  logic           ft_oe_n_i,
  input  logic [7:0]     h2f_data_i,
  input  logic           h2f_valid_i,
  output logic           h2f_ready_o,
  output logic [7:0]     f2h_data_o,
  output logic           f2h_valid_o,
  input  logic           f2h_ready_i,
  output logic [3:0]     err_o,
  input  logic           err_clr_i,
  output logic [RLW-1:0] rx_level_o,
  output logic [TLW-1:0] tx_level_o
);

  localparam int BW = (TX_BURST > 0) ? $clog2(TX_BURST + 1) : 1;
  localparam int GW = $clog2(TX_GAP + 1);

  logic [RLW-1:0] rx_level_next;
  logic [TLW-1:0] tx_level_next;
  logic           rx_full, rx_empty, tx_full, tx_empty;
  logic           rx_push, rx_pop, tx_capture, tx_pop;
  logic           rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic [3:0]     err_q, err_d, err_set;
  txe_state_t     state_q, state_d;
  logic [BW-1:0]  burst_q, burst_d, burst_inc;
  logic [GW-1:0]  gap_q, gap_d;

  assign rx_push      = h2f_valid_i && h2f_ready_o;
  assign h2f_ready_o  = !rx_full;
  assign rx_pop       = !ft_rd_n_i && !ft_oe_n_i && !rxf_n_q;
  assign ft_data_oe_o = !ft_oe_n_i;
  assign tx_capture   = !ft_wr_n_i && !txe_n_q && ft_oe_n_i;
  assign f2h_valid_o  = !tx_empty;
  assign tx_pop       = f2h_valid_o && f2h_ready_i;
  assign burst_inc    = burst_q + BW'(1);

  sync_fifo_sa #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push), .pop_i(rx_pop),
    .data_i(h2f_data_i), .data_o(ft_data_o), .level_o(rx_level_o),
    .level_next_o(rx_level_next), .full_o(rx_full), .empty_o(rx_empty)
  );

  sync_fifo_sa #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_capture), .pop_i(tx_pop),
    .data_i(ft_data_i), .data_o(f2h_data_o), .level_o(tx_level_o),
    .level_next_o(tx_level_next), .full_o(tx_full), .empty_o(tx_empty)
  );

  // TXE# pacing: burst counting in OPEN, forced-high window in GAP.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    txe_n_d = 1'b1;
    case (state_q)
      OPEN: begin
        if (tx_capture) begin
          if ((TX_BURST != 0) && (burst_inc == BW'(TX_BURST))) begin
            state_d = GAP;
            burst_d = '0;
            gap_d   = GW'(TX_GAP);
          end else begin
            burst_d = burst_inc;
          end
        end else begin
          burst_d = burst_q;
        end
        txe_n_d = (state_d == GAP) ? 1'b1 : (tx_level_next == TLW'(TX_DEPTH));
      end
      GAP: begin
        if (gap_q == GW'(1)) begin
          state_d = OPEN;
          txe_n_d = (tx_level_next == TLW'(TX_DEPTH));
        end else begin
          gap_d   = gap_q - GW'(1);
          txe_n_d = 1'b1;
        end
      end
      default: begin
        state_d = OPEN;
        txe_n_d = 1'b0;
      end
    endcase
  end

  // Sticky protocol-violation flags; clear wins over a same-cycle set.
  always_comb begin
    err_set               = 4'b0000;
    err_set[ERR_TXE_WR]   = !ft_wr_n_i && txe_n_q;
    err_set[ERR_RXF_RD]   = !ft_rd_n_i && rxf_n_q;
    err_set[ERR_RD_NO_OE] = !ft_rd_n_i && ft_oe_n_i;
    err_set[ERR_OE_WR]    = !ft_wr_n_i && !ft_oe_n_i;
    if (err_clr_i) begin
      err_d = 4'b0000;
    end else begin
      err_d = err_q | err_set;
    end
  end

  assign rxf_n_d = (rx_level_next == RLW'(0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OPEN;
      burst_q <= '0;
      gap_q   <= '0;
      rxf_n_q <= 1'b1;
      txe_n_q <= 1'b0;
      err_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      rxf_n_q <= rxf_n_d;
      txe_n_q <= txe_n_d;
      err_q   <= err_d;
    end
  end

  assign ft_rxf_n_o = rxf_n_q;
  assign ft_txe_n_o = txe_n_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ft232h_fifo_responder.sv
// Scoreboard bench: expected bytes queued at stimulus time, compared by a negedge monitor.
module tb_ft232h_fifo_responder;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] ft_data_i, ft_data_o, h2f_data_i, f2h_data_o;
  logic       ft_data_oe_o, ft_rxf_n_o, ft_txe_n_o;
  logic       ft_rd_n_i, ft_wr_n_i, ft_oe_n_i;
  logic       h2f_valid_i, h2f_ready_o, f2h_valid_o, f2h_ready_i;
  logic [3:0] err_o;
  logic       err_clr_i;
  logic [4:0] rx_level_o, tx_level_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] f2h_exp[$];

  always #5 clk = ~clk;

  ft232h_fifo_responder #(.RX_DEPTH(16), .TX_DEPTH(16), .TX_BURST(4), .TX_GAP(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .ft_data_i(ft_data_i), .ft_data_o(ft_data_o),
    .ft_data_oe_o(ft_data_oe_o), .ft_rxf_n_o(ft_rxf_n_o), .ft_txe_n_o(ft_txe_n_o),
    .ft_rd_n_i(ft_rd_n_i), .ft_wr_n_i(ft_wr_n_i), .ft_oe_n_i(ft_oe_n_i),
    .h2f_data_i(h2f_data_i), .h2f_valid_i(h2f_valid_i), .h2f_ready_o(h2f_ready_o),
    .f2h_data_o(f2h_data_o), .f2h_valid_o(f2h_valid_o), .f2h_ready_i(f2h_ready_i),
    .err_o(err_o), .err_clr_i(err_clr_i), .rx_level_o(rx_level_o), .tx_level_o(tx_level_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every byte the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && !ft_rd_n_i && !ft_oe_n_i && !ft_rxf_n_o) begin
      if (rx_exp.size() == 0) chk("rx_unexpected", {24'd0, ft_data_o}, 32'hFFFF_FFFF);
      else chk("rx_byte", {24'd0, ft_data_o}, {24'd0, rx_exp.pop_front()});
    end
    if (!rst_i && f2h_valid_o && f2h_ready_i) begin
      if (f2h_exp.size() == 0) chk("f2h_unexpected", {24'd0, f2h_data_o}, 32'hFFFF_FFFF);
      else chk("f2h_byte", {24'd0, f2h_data_o}, {24'd0, f2h_exp.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int idx;
    int gap_cycles;
    int n;
    logic txe_before;
    rst_i = 1'b1; ft_data_i = 8'h00; ft_rd_n_i = 1'b1; ft_wr_n_i = 1'b1; ft_oe_n_i = 1'b1;
    h2f_data_i = 8'h00; h2f_valid_i = 1'b0; f2h_ready_i = 1'b0; err_clr_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_rxf_n", 32'(ft_rxf_n_o), 32'd1);
    chk("rst_txe_n", 32'(ft_txe_n_o), 32'd0);
    chk("rst_h2f_ready", 32'(h2f_ready_o), 32'd1);
    chk("rst_f2h_valid", 32'(f2h_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rx_level", 32'(rx_level_o), 32'd0);
    chk("rst_tx_level", 32'(tx_level_o), 32'd0);
    chk("rst_ft_data", 32'(ft_data_o), 32'd0);

    // RX: fill with 0x00..0x0F, then read back-to-back.
    for (int i = 0; i < 16; i++) begin
      h2f_valid_i = 1'b1; h2f_data_i = 8'(i);
      rx_exp.push_back(8'(i));
      tick();
      if (i == 0) chk("rxf_low_after_first_push", 32'(ft_rxf_n_o), 32'd0);
    end
    h2f_valid_i = 1'b0;
    chk("rx_full_level", 32'(rx_level_o), 32'd16);
    chk("rx_full_ready", 32'(h2f_ready_o), 32'd0);
    ft_oe_n_i = 1'b0;
    tick();
    chk("oe_drives_bus", 32'(ft_data_oe_o), 32'd1);
    ft_rd_n_i = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("rxf_high_on_last_pop", 32'(ft_rxf_n_o), 32'd1);
    chk("rx_level_drained", 32'(rx_level_o), 32'd0);
    tick();
    ft_rd_n_i = 1'b1; ft_oe_n_i = 1'b1;
    chk("rd_past_empty_err", 32'(err_o), 32'h2);
    chk("rd_past_empty_level", 32'(rx_level_o), 32'd0);
    chk("rx_scoreboard_empty", 32'(rx_exp.size()), 32'd0);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("err_clr", 32'(err_o), 32'd0);

    // TX burst/gap: WR# held low, bridge retries the byte refused during the gap.
    f2h_ready_i = 1'b1; ft_wr_n_i = 1'b0; idx = 0; gap_cycles = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      ft_data_i = 8'hA0 + 8'(idx);
      txe_before = ft_txe_n_o;
      if (txe_before) gap_cycles++;
      tick();
      if (!txe_before) begin
        f2h_exp.push_back(8'hA0 + 8'(idx));
        idx++;
      end
    end
    ft_wr_n_i = 1'b1;
    chk("burst_bytes_accepted", 32'(idx), 32'd8);
    chk("gap_cycles", 32'(gap_cycles), 32'd3);
    chk("txe_high_after_burst", 32'(ft_txe_n_o), 32'd1);
    for (int c = 0; c < 20 && f2h_exp.size() != 0; c++) tick();
    chk("burst_drained", 32'(f2h_exp.size()), 32'd0);
    chk("gap_write_err", 32'(err_o), 32'h1);
    for (int c = 0; c < 4; c++) tick();
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

    // TX full: no f2h drain, 16 obeying writes then 4 writes against TXE# high.
    f2h_ready_i = 1'b0; n = 0;
    for (int c = 0; c < 100 && n < 16; c++) begin
      if (!ft_txe_n_o) begin
        ft_wr_n_i = 1'b0; ft_data_i = 8'h10 + 8'(n);
        f2h_exp.push_back(8'h10 + 8'(n));
        n++;
      end else begin
        ft_wr_n_i = 1'b1;
      end
      tick();
    end
    ft_wr_n_i = 1'b1;
    chk("tx_full_level", 32'(tx_level_o), 32'd16);
    chk("tx_full_txe", 32'(ft_txe_n_o), 32'd1);
    chk("tx_full_no_err", 32'(err_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      ft_wr_n_i = 1'b0; ft_data_i = 8'hEE; tick();
    end
    ft_wr_n_i = 1'b1;
    chk("tx_overwrite_err", 32'(err_o), 32'h1);
    chk("tx_overwrite_level", 32'(tx_level_o), 32'd16);
    chk("tx_full_txe_held", 32'(ft_txe_n_o), 32'd1);
    f2h_ready_i = 1'b1;
    for (int c = 0; c < 40 && f2h_exp.size() != 0; c++) tick();
    tick();
    chk("tx_drained_level", 32'(tx_level_o), 32'd0);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

    // OE# and WR# low together: byte dropped, err[3].
    ft_oe_n_i = 1'b0; ft_wr_n_i = 1'b0; ft_data_i = 8'h55; tick();
    ft_oe_n_i = 1'b1; ft_wr_n_i = 1'b1; tick();
    chk("oe_wr_err", 32'(err_o), 32'h8);
    chk("oe_wr_level", 32'(tx_level_o), 32'd0);
    // Clear beats a same-cycle set; then RD# without OE# on an empty buffer.
    err_clr_i = 1'b1; ft_rd_n_i = 1'b0; tick();
    chk("clr_priority", 32'(err_o), 32'd0);
    err_clr_i = 1'b0; tick();
    ft_rd_n_i = 1'b1;
    chk("rd_no_oe_err", 32'(err_o), 32'h6);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;

    // Reset mid-transfer discards buffered bytes.
    for (int i = 0; i < 5; i++) begin
      h2f_valid_i = 1'b1; h2f_data_i = 8'h30 + 8'(i); tick();
    end
    h2f_valid_i = 1'b0;
    chk("pre_reset_level", 32'(rx_level_o), 32'd5);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("post_reset_level", 32'(rx_level_o), 32'd0);
    chk("post_reset_rxf", 32'(ft_rxf_n_o), 32'd1);
    chk("post_reset_ready", 32'(h2f_ready_o), 32'd1);
    tick();
    chk("final_rx_queue", 32'(rx_exp.size()), 32'd0);
    chk("final_f2h_queue", 32'(f2h_exp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
